// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// over one shared ALU and one unified memory port, and counts retired instructions.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_EXEC_U    = 4'd9,
        S_ALU_WB    = 4'd10,
        S_BRANCH    = 4'd11,
        S_JAL       = 4'd12,
        S_JALR      = 4'd13,
        S_ILLEGAL   = 4'd15
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        alu_op        = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        reg_write     = 1'b0;
        mem_to_reg    = 2'b00;
        illegal       = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                // IR/PC load is the only Mealy output: it must coincide with the completing beat
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (opcode)
                    7'b0000011, 7'b0100011: state_d = S_MEM_ADDR;
                    7'b0110011:             state_d = S_EXEC_R;
                    7'b0010011:             state_d = S_EXEC_I;
                    7'b0110111, 7'b0010111: state_d = S_EXEC_U;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR;
                    default:                state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                state_d   = S_ALU_WB;
            end
            S_EXEC_U: begin
                alu_src_a = opcode[5] ? 2'b11 : 2'b10;
                alu_src_b = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 2'b01;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                pc_source  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ILLEGAL: illegal = 1'b1;
            default:   state_d = S_ILLEGAL;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state/control words are queued per
// instruction and compared as the FSM steps; a narrow counter exercises retire wrap-around.
module tb_multicycle_control;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       opcode = '0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source;
    logic [1:0]       alu_op, alu_src_a, alu_src_b, mem_to_reg;
    logic             reg_write, illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source;
        logic [1:0] alu_op, alu_src_a, alu_src_b;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        logic [3:0] st;
        ctrl_t      c;
        logic       rdy;
    } exp_t;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_BAD = 7'b1111111;

    ctrl_t            act;
    exp_t             sb[$];
    int               checks = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_ret = '0;

    assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source,
                  alu_op, alu_src_a, alu_src_b, reg_write, mem_to_reg, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Control word each state must present, written straight from the state table.
    function automatic ctrl_t ctrl_of(input logic [3:0] st, input logic [6:0] opc, input logic rdy);
        ctrl_t c = '0;
        case (st)
            4'd1:  begin c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            4'd2:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; end
            4'd3:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
            4'd4:  begin c.mem_req = 1; c.iord = 1; end
            4'd5:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
            4'd6:  begin c.mem_req = 1; c.mem_we = 1; c.iord = 1; end
            4'd7:  begin c.alu_src_a = 2'b01; c.alu_op = 2'b10; end
            4'd8:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
            4'd9:  begin c.alu_src_a = (opc == OP_LUI) ? 2'b11 : 2'b10; c.alu_src_b = 2'b10; end
            4'd10: c.reg_write = 1;
            4'd11: begin c.alu_src_a = 2'b01; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 1; end
            4'd12: begin c.reg_write = 1; c.mem_to_reg = 2'b10; c.pc_write = 1; c.pc_source = 1; end
            4'd13: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.reg_write = 1;
                         c.mem_to_reg = 2'b10; c.pc_write = 1; end
            4'd15: c.illegal = 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy, input logic [6:0] opc);
        exp_t e;
        e.st  = st;
        e.rdy = rdy;
        e.c   = ctrl_of(st, opc, rdy);
        sb.push_back(e);
    endtask

    task automatic push_mem(input logic [3:0] st, input int unsigned waits, input logic [6:0] opc);
        repeat (waits) push(st, 1'b0, opc);
        push(st, 1'b1, opc);
    endtask

    // Non-memory states get a random mem_ready: it must have no effect there.
    task automatic push_nm(input logic [3:0] st, input logic [6:0] opc);
        push(st, 1'($urandom_range(1)), opc);
    endtask

    task automatic drain(input logic [6:0] opc, input string name);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode    = opc;
            mem_ready = e.rdy;
            @(negedge clk);
            check($sformatf("%s st%0d state", name, e.st), 32'(state), 32'(e.st));
            check($sformatf("%s st%0d ctrl", name, e.st), 32'(act), 32'(e.c));
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic instr(input logic [6:0] opc, input int unsigned fw, input int unsigned mw,
                         input string name);
        push_mem(4'd1, fw, opc);
        push_nm(4'd2, opc);
        case (opc)
            OP_LW:           begin push_nm(4'd3, opc); push_mem(4'd4, mw, opc); push_nm(4'd5, opc); end
            OP_SW:           begin push_nm(4'd3, opc); push_mem(4'd6, mw, opc); end
            OP_R:            begin push_nm(4'd7, opc); push_nm(4'd10, opc); end
            OP_I:            begin push_nm(4'd8, opc); push_nm(4'd10, opc); end
            OP_LUI, OP_AUIPC: begin push_nm(4'd9, opc); push_nm(4'd10, opc); end
            OP_BR:           push_nm(4'd11, opc);
            OP_JAL:          push_nm(4'd12, opc);
            OP_JALR:         push_nm(4'd13, opc);
            default: ;
        endcase
        drain(opc, name);
        exp_ret = exp_ret + CNT_W'(1);
        check({name, " retired"}, 32'(retired), 32'(exp_ret));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset ctrl", 32'(act), 32'd0);
        check("reset retired", 32'(retired), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // lw interrupted by reset while waiting in MEM_READ
        push_mem(4'd1, 0, OP_LW);
        push(4'd2, 1'b0, OP_LW);
        push(4'd3, 1'b0, OP_LW);
        push(4'd4, 1'b0, OP_LW);
        drain(OP_LW, "lw_abort");
        #2;
        rst = 1'b1;
        #1;
        check("async rst state", 32'(state), 32'd0);
        check("async rst mem_req", 32'(mem_req), 32'd0);
        check("async rst retired", 32'(retired), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-rst idle", 32'(state), 32'd0);
        @(posedge clk); #1;

        instr(OP_R,     0, 0, "add");
        instr(OP_LW,    0, 3, "lw_wait3");
        instr(OP_SW,    0, 1, "sw");
        instr(OP_BR,    0, 0, "beq");
        instr(OP_LUI,   0, 0, "lui");
        instr(OP_AUIPC, 0, 0, "auipc");
        instr(OP_JAL,   0, 0, "jal");
        instr(OP_JALR,  0, 0, "jalr");
        instr(OP_I,     1, 0, "addi_fwait");
        instr(OP_LW,    2, 0, "lw_fwait");

        while (exp_ret != '0) instr(OP_R, $urandom_range(2), 0, "add_fill");
        check("wrap retired", 32'(retired), 32'd0);

        push_mem(4'd1, 0, OP_BAD);
        push_nm(4'd2, OP_BAD);
        drain(OP_BAD, "illegal_entry");
        for (int i = 0; i < 100; i++) begin
            mem_ready = 1'($urandom_range(1));
            @(negedge clk);
            check("illegal state", 32'(state), 32'd15);
            check("illegal flag", 32'(illegal), 32'd1);
            check("illegal mem_req", 32'(mem_req), 32'd0);
            @(posedge clk); #1;
        end
        check("illegal retired", 32'(retired), 32'(exp_ret));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
